seq_pattern_tx: RTL and testbench

Serial pattern transmitter that drives the one-bit `j` stream consumed by the mealy sequence detector. It captures a parallel pattern and a repeat count on a start request. It then shifts the pattern out MSB-first, one bit per clock, with a fixed zero gap between repetitions. It sits upstream of the detector in system-level benches and board demos, replacing hand-written `j` stimulus.

---
 rtl/seq_pattern_tx_pkg.sv | 10 +
 rtl/seq_pattern_tx_if.sv | 16 +
 rtl/seq_pattern_tx_piso_shift_reg.sv | 25 ++
 rtl/seq_pattern_tx.sv | 116 +++++++++++
 tb/tb_seq_pattern_tx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} seq_tx_state_t;

    localparam int SEQ_TX_WIDTH = 8;
    localparam int SEQ_TX_GAP   = 2;
    localparam int SEQ_TX_REP_W = 4;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle between a pattern source and seq_pattern_tx.
interface seq_pattern_tx_if import seq_tx_pkg::*; #(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int REP_W = SEQ_TX_REP_W
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] reps;
    logic             j;
    logic             j_valid;
    logic             busy;
    logic             done;

    modport master (output start, pattern, reps, input j, j_valid, busy, done);
    modport slave  (input start, pattern, reps, output j, j_valid, busy, done);
endinterface

// File: rtl/seq_pattern_tx_piso_shift_reg.sv
// Parallel-in serial-out register: parallel load wins over shift, MSB leaves first.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = r_data;
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, N times, with
// a fixed idle gap between copies. Outputs are registered images of the state.
module seq_pattern_tx import seq_tx_pkg::*; #(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int GAP   = SEQ_TX_GAP,
    parameter int REP_W = SEQ_TX_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int BW       = $clog2(WIDTH);
    localparam int GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    seq_tx_state_t    r_state, w_state_nxt;
    logic [BW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [REP_W-1:0] r_rep_cnt;
    logic [WIDTH-1:0] r_pat;
    logic             r_j, r_j_valid, r_busy, r_done;

    logic             w_accept, w_last_bit, w_last_rep, w_last_gap;
    logic             w_load, w_shift;
    logic [WIDTH-1:0] w_load_val, w_dout;

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_last_bit = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_last_rep = (r_rep_cnt == REP_W'(1));
    assign w_last_gap = (r_gap_cnt == GW'(GAP_LAST));
    // Repeats reload from the private copy so the source may move on.
    assign w_load_val = (r_state == IDLE) ? bus.pattern : r_pat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (bus.reps != '0) ? SEND : FIN;
                end
            end
            SEND: begin
                if (!w_last_bit) begin
                    w_shift = 1'b1;
                end else if (w_last_rep) begin
                    w_state_nxt = FIN;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = (GAP > 0) ? seq_tx_pkg::GAP : SEND;
                end
            end
            seq_tx_pkg::GAP: begin
                if (w_last_gap) w_state_nxt = SEND;
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters are held at zero outside their own state, so every entry starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_rep_cnt <= '0;
            r_pat     <= '0;
        end else begin
            if (w_accept) begin
                r_pat     <= bus.pattern;
                r_rep_cnt <= bus.reps;
            end else if (r_state == SEND && w_last_bit) begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
            end
            if (r_state == SEND) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            else                 r_bit_cnt <= '0;
            if (r_state == seq_tx_pkg::GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                            r_gap_cnt <= '0;
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_load_val),
        .dout  (w_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_j       <= 1'b0;
            r_j_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_j       <= (r_state == SEND) && w_dout[WIDTH-1];
            r_j_valid <= (r_state == SEND);
            r_busy    <= (r_state != IDLE);
            r_done    <= (r_state == FIN);
        end
    end

    assign bus.j       = r_j;
    assign bus.j_valid = r_j_valid;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected (edge, bit), done
// edges and busy lengths; monitors pop and compare as the DUTs produce them.
module tb_seq_pattern_tx;
    localparam int W  = 8;
    localparam int G  = 2;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) bus  ();
    seq_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) bus0 ();

    seq_pattern_tx #(.WIDTH(W), .GAP(G), .REP_W(RW)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_pattern_tx #(.WIDTH(W), .GAP(0), .REP_W(RW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct {int cyc; logic b;} bit_t;
    bit_t q_bit[$];
    bit_t q_bit0[$];
    int   q_done[$];
    int   q_done0[$];
    int   q_busy[$];

    int cyc      = 0;
    int n_chk    = 0;
    int n_fail   = 0;
    int busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Start sampled at edge k: bit i of copy r appears at edge k+1+r*(W+gap)+i.
    task automatic expect_tx(input logic [W-1:0] pat, input int n, input int gap,
                             input int k, input bit on0, output int d);
        bit_t e;
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < W; i++) begin
                e.cyc = k + 1 + r * (W + gap) + i;
                e.b   = pat[W-1-i];
                if (on0) q_bit0.push_back(e);
                else     q_bit.push_back(e);
            end
        end
        d = k + 1 + n * W + ((n > 0) ? (n - 1) * gap : 0);
        if (on0) q_done0.push_back(d);
        else begin
            q_done.push_back(d);
            q_busy.push_back(d - k);
        end
    endtask

    // Called at a negedge; returns at the negedge right after done, so a
    // following call is a back-to-back start.
    task automatic send(input logic [W-1:0] pat, input logic [RW-1:0] n, input bit on0, input bit poke);
        int k;
        int d;
        if (on0) begin bus0.start = 1'b1; bus0.pattern = pat; bus0.reps = n; end
        else     begin bus.start  = 1'b1; bus.pattern  = pat; bus.reps  = n; end
        k = cyc + 1;
        expect_tx(pat, int'(n), on0 ? 0 : G, k, on0, d);
        @(negedge clk);
        if (on0) begin bus0.start = 1'b0; bus0.pattern = ~pat; bus0.reps = n + 4'd3; end
        else     begin bus.start  = 1'b0; bus.pattern  = ~pat; bus.reps  = n + 4'd3; end
        for (int t = 0; t < 200 && cyc < d; t++) begin
            @(negedge clk);
            if (poke && t == 3) begin
                bus.start = 1'b1; bus.pattern = 8'hFF; bus.reps = 4'd5;
            end else if (!on0) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("done_reached", cyc >= d, 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            busy_run = 0;
        end else begin
            if (bus.j_valid) begin
                if (q_bit.size() == 0) chk("stray_bit", bus.j_valid, 0);
                else begin
                    bit_t e;
                    e = q_bit.pop_front();
                    chk("bit_cycle", cyc, e.cyc);
                    chk("bit_value", bus.j, e.b);
                end
            end else begin
                chk("idle_j_zero", bus.j, 0);
            end
            if (bus.done) begin
                if (q_done.size() == 0) chk("stray_done", bus.done, 0);
                else                    chk("done_cycle", cyc, q_done.pop_front());
            end
            if (bus.busy) busy_run++;
            else if (busy_run > 0) begin
                if (q_busy.size() == 0) chk("stray_busy", busy_run, 0);
                else                    chk("busy_len", busy_run, q_busy.pop_front());
                busy_run = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (bus0.j_valid) begin
                if (q_bit0.size() == 0) chk("gap0_stray_bit", bus0.j_valid, 0);
                else begin
                    bit_t e;
                    e = q_bit0.pop_front();
                    chk("gap0_bit_cycle", cyc, e.cyc);
                    chk("gap0_bit_value", bus0.j, e.b);
                end
            end
            if (bus0.done) begin
                if (q_done0.size() == 0) chk("gap0_stray_done", bus0.done, 0);
                else                     chk("gap0_done_cycle", cyc, q_done0.pop_front());
            end
        end
    end

    initial begin
        int k;
        int d;
        bus.start  = 1'b0; bus.pattern  = '0; bus.reps  = '0;
        bus0.start = 1'b0; bus0.pattern = '0; bus0.reps = '0;
        repeat (2) @(negedge clk);
        chk("rst_j", bus.j, 0);
        chk("rst_j_valid", bus.j_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b1;
        @(negedge clk);

        send(8'hB2, 4'd1, 1'b0, 1'b0);
        send(8'hA5, 4'd3, 1'b0, 1'b0);
        send(8'h3C, 4'd0, 1'b0, 1'b0);
        send(8'h6E, 4'd2, 1'b0, 1'b1);
        repeat (12) @(negedge clk);

        send(8'hC3, 4'd2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset lands after the third bit of B2.
        bus.start = 1'b1; bus.pattern = 8'hB2; bus.reps = 4'd1;
        k = cyc + 1;
        expect_tx(8'hB2, 1, G, k, 1'b0, d);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_j", bus.j, 0);
        chk("midrst_j_valid", bus.j_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        q_bit.delete(); q_done.delete(); q_busy.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h0F, 4'd1, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        chk("queues_drained",
            q_bit.size() + q_bit0.size() + q_done.size() + q_done0.size() + q_busy.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
